// File: rtl/ram_master_pkg.sv
// Shared types and constants for the ram_master bus initiator.
package ram_master_pkg;

    localparam int unsigned AW_DEF = 8;
    localparam int unsigned DW_DEF = 32;
    localparam int unsigned DEPTH  = 256;

    localparam logic [DW_DEF-1:0] BUS_Z = {DW_DEF{1'bz}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_ADDR,
        S_RD_CAP,
        S_RD_OUT,
        S_DONE
    } state_e;

endpackage

// File: rtl/ram_master.sv
// Burst initiator for the 256x32 single-port RAM: converts valid/ready bursts
// into wr_en/rd_en strobes and owns the shared tri-state data bus.
module ram_master
    import ram_master_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_wr_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [AW-1:0] req_len_i,
    input  logic          wdata_valid_i,
    input  logic [DW-1:0] wdata_i,
    output logic          wdata_ready_o,
    output logic          rdata_valid_o,
    output logic [DW-1:0] rdata_o,
    input  logic          rdata_ready_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          mem_wr_en_o,
    output logic          mem_rd_en_o,
    output logic [AW-1:0] mem_addr_o,
    inout  wire  [DW-1:0] mem_data_io
);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          mem_wr_en_q, mem_wr_en_d;
    logic          mem_rd_en_q, mem_rd_en_d;
    logic          drive_q, drive_d;
    logic          rdata_valid_q, rdata_valid_d;
    logic          done_q, done_d;
    logic          wr_strobe;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        wr_strobe = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    cnt_d   = req_len_i;
                    state_d = req_wr_i ? S_WR : S_RD_ADDR;
                end
            end
            S_WR: begin
                if (wdata_valid_i) begin
                    wr_strobe = 1'b1;
                    wdata_d   = wdata_i;
                    addr_d    = addr_q + 1'b1;
                    cnt_d     = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RD_ADDR: state_d = S_RD_CAP;
            S_RD_CAP: begin
                // RAM is driving its registered word during this cycle
                rdata_d = mem_data_io;
                state_d = S_RD_OUT;
            end
            S_RD_OUT: begin
                if (rdata_ready_i) begin
                    addr_d  = addr_q + 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (cnt_q == '0) ? S_DONE : S_RD_ADDR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered from the next state so they line up with it
        mem_wr_en_d   = wr_strobe;
        drive_d       = wr_strobe;
        mem_rd_en_d   = (state_d == S_RD_ADDR) || (state_d == S_RD_CAP);
        mem_addr_d    = wr_strobe ? addr_q
                      : (state_d == S_RD_ADDR) ? addr_d : mem_addr_q;
        rdata_valid_d = (state_d == S_RD_OUT);
        done_d        = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            cnt_q         <= '0;
            mem_addr_q    <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            drive_q       <= 1'b0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            mem_addr_q    <= mem_addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_rd_en_q   <= mem_rd_en_d;
            drive_q       <= drive_d;
            rdata_valid_q <= rdata_valid_d;
            done_q        <= done_d;
        end
    end

    assign mem_data_io   = drive_q ? wdata_q : BUS_Z;

    assign req_ready_o   = (state_q == S_IDLE);
    assign busy_o        = (state_q != S_IDLE);
    assign wdata_ready_o = (state_q == S_WR);
    assign rdata_valid_o = rdata_valid_q;
    assign rdata_o       = rdata_q;
    assign done_o        = done_q;
    assign mem_wr_en_o   = mem_wr_en_q;
    assign mem_rd_en_o   = mem_rd_en_q;
    assign mem_addr_o    = mem_addr_q;

endmodule

// File: tb/tb_ram_master.sv
// Scoreboard bench for ram_master with a behavioural 256x32 RAM on the mem_* bus.
module tb_ram_master;
    import ram_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wr;
    logic [7:0]  req_addr, req_len;
    logic        wdata_valid, wdata_ready;
    logic [31:0] wdata;
    logic        rdata_valid, rdata_ready;
    logic [31:0] rdata;
    logic        busy, done;
    logic        mem_wr_en, mem_rd_en;
    logic [7:0]  mem_addr;
    wire  [31:0] mem_data;

    ram_master #(.AW(8), .DW(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wr_i(req_wr),
        .req_addr_i(req_addr), .req_len_i(req_len),
        .wdata_valid_i(wdata_valid), .wdata_i(wdata), .wdata_ready_o(wdata_ready),
        .rdata_valid_o(rdata_valid), .rdata_o(rdata), .rdata_ready_i(rdata_ready),
        .busy_o(busy), .done_o(done),
        .mem_wr_en_o(mem_wr_en), .mem_rd_en_o(mem_rd_en),
        .mem_addr_o(mem_addr), .mem_data_io(mem_data)
    );

    always #5 clk = ~clk;

    // Slave RAM: registers the word on rd_en, drives it while rd_en is held.
    logic [31:0] ram [DEPTH];
    logic [31:0] ram_q;
    logic        ram_rd_q;
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_addr] <= mem_data;
        if (mem_rd_en) ram_q <= ram[mem_addr];
        ram_rd_q <= mem_rd_en;
    end
    assign mem_data = (mem_rd_en && ram_rd_q) ? ram_q : 'z;

    int unsigned n_checks = 0, n_fail = 0;
    logic [31:0] exp_mem [DEPTH];
    logic [31:0] sb [$];
    logic [31:0] wq [$];
    int unsigned gq [$];
    int unsigned wr_pulses = 0, wr_run = 0, rd_cycles = 0, done_cnt = 0;
    int unsigned n_conflict = 0, n_drive_err = 0, n_popped = 0, last_busy_low = 0;
    logic        prev_wr = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_wr_en && mem_rd_en) n_conflict++;
        if (dut.drive_q && mem_rd_en) n_conflict++;
        if (dut.drive_q !== mem_wr_en) n_drive_err++;
        if (mem_wr_en) wr_pulses++;
        if (mem_wr_en && prev_wr) wr_run++;
        prev_wr = mem_wr_en;
        if (mem_rd_en) rd_cycles++;
        if (done) done_cnt++;
        if (rdata_valid && rdata_ready) begin
            if (sb.size() == 0) check("sb_underflow", rdata, 32'hFFFF_FFFF ^ rdata);
            else begin
                check("rdata", rdata, sb.pop_front());
                n_popped++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic wr, input logic [7:0] addr, input logic [7:0] len);
        int unsigned n = 0;
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_len = len;
        @(negedge clk);
        while (!req_ready && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) check("req_timeout", 32'd0, 32'd1);
        tick();
        // Scramble request fields; the DUT must ignore them now.
        req_valid = 1'b0; req_wr = ~wr; req_addr = ~addr; req_len = ~len;
    endtask

    task automatic fill_wq(input logic [31:0] base, input int unsigned count);
        wq.delete();
        for (int unsigned i = 0; i < count; i++) wq.push_back(base + i);
    endtask

    task automatic write_burst(input logic [7:0] addr, input logic [7:0] len, input int unsigned nbeats);
        int unsigned busy_low = 0;
        int unsigned n;
        send_req(1'b1, addr, len);
        for (int unsigned i = 0; i < nbeats; i++) begin
            wdata_valid = 1'b0;
            for (int unsigned g = 0; g < ((gq.size() > i) ? gq[i] : 0); g++) begin
                @(negedge clk);
                if (!busy) busy_low++;
                tick();
            end
            wdata_valid = 1'b1;
            wdata = wq[i];
            n = 0;
            @(negedge clk);
            while (!wdata_ready && n < 100) begin @(negedge clk); n++; end
            if (n >= 100) check("wdata_timeout", 32'd0, 32'd1);
            if (!busy) busy_low++;
            exp_mem[8'(addr + i)] = wq[i];
            tick();
        end
        wdata_valid = 1'b0;
        wdata = '1;
        last_busy_low = busy_low;
    endtask

    task automatic read_burst(input logic [7:0] addr, input logic [7:0] len);
        for (int unsigned i = 0; i <= len; i++) sb.push_back(exp_mem[8'(addr + i)]);
        send_req(1'b0, addr, len);
    endtask

    task automatic wait_done(input string tag, input int unsigned start);
        int unsigned n = 0;
        while (done_cnt == start && n < 5000) begin tick(); n++; end
        tick(); tick();
        check(tag, done_cnt - start, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned d0, w0, r0, p0, n, unstable;
        logic [31:0] snap;

        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
        wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b1;
        repeat (3) tick();
        check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        check("rst_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_rvalid", {31'd0, rdata_valid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_drive", {31'd0, dut.drive_q}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;
        tick();

        // Wrapping write then read at 0xFE
        gq.delete(); fill_wq(32'hA0, 4);
        d0 = done_cnt;
        write_burst(8'hFE, 8'd3, 4);
        wait_done("wr_wrap_done", d0);
        check("ram_fe", ram[8'hFE], 32'hA0);
        check("ram_ff", ram[8'hFF], 32'hA1);
        check("ram_00", ram[8'h00], 32'hA2);
        check("ram_01", ram[8'h01], 32'hA3);
        p0 = n_popped; d0 = done_cnt;
        read_burst(8'hFE, 8'd3);
        wait_done("rd_wrap_done", d0);
        check("rd_wrap_beats", n_popped - p0, 32'd4);

        // Single read latency
        wq.delete(); wq.push_back(32'h1234_5678);
        d0 = done_cnt;
        write_burst(8'h10, 8'd0, 1);
        wait_done("wr10_done", d0);
        r0 = rd_cycles; d0 = done_cnt;
        read_burst(8'h10, 8'd0);
        n = 0;
        do begin @(negedge clk); n++; end while (!rdata_valid && n < 20);
        check("rd_latency", n, 32'd3);
        check("rd_lat_data", rdata, 32'h1234_5678);
        wait_done("rd10_done", d0);
        check("rd_en_cycles", rd_cycles - r0, 32'd2);

        // Read back-pressure
        fill_wq(32'hCAFE_0040, 2);
        d0 = done_cnt;
        write_burst(8'h40, 8'd1, 2);
        wait_done("wr40_done", d0);
        rdata_ready = 1'b0;
        p0 = n_popped; d0 = done_cnt;
        read_burst(8'h40, 8'd1);
        n = 0;
        @(negedge clk);
        while (!rdata_valid && n < 20) begin @(negedge clk); n++; end
        snap = rdata; r0 = rd_cycles; unstable = 0;
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!rdata_valid || rdata !== snap) unstable++;
        end
        check("stall_first", snap, 32'hCAFE_0040);
        check("stall_stable", unstable, 32'd0);
        check("stall_no_rd", rd_cycles - r0, 32'd0);
        tick();
        rdata_ready = 1'b1;
        wait_done("stall_done", d0);
        check("stall_beats", n_popped - p0, 32'd2);

        // Write with valid gaps
        fill_wq(32'h0BAD_0080, 3);
        gq.delete(); gq.push_back(0); gq.push_back(3); gq.push_back(1);
        w0 = wr_pulses; n = wr_run; d0 = done_cnt;
        write_burst(8'h80, 8'd2, 3);
        wait_done("gap_done", d0);
        gq.delete();
        check("gap_pulses", wr_pulses - w0, 32'd3);
        check("gap_single", wr_run - n, 32'd0);
        check("gap_busy", last_busy_low, 32'd0);
        check("gap_ram", ram[8'h81], 32'h0BAD_0081);

        // Reset in the middle of an 8-beat write
        fill_wq(32'h5555_00C0, 8);
        d0 = done_cnt;
        write_burst(8'hC0, 8'd7, 8);
        wait_done("pre_done", d0);
        fill_wq(32'h0000_00B0, 3);
        d0 = done_cnt;
        write_burst(8'hC0, 8'd7, 3);
        tick(); tick();
        rst = 1'b1;
        #1;
        check("mid_rst_wr", {31'd0, mem_wr_en}, 32'd0);
        check("mid_rst_rd", {31'd0, mem_rd_en}, 32'd0);
        check("mid_rst_addr", {24'd0, mem_addr}, 32'd0);
        check("mid_rst_drive", {31'd0, dut.drive_q}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        repeat (3) tick();
        check("mid_rst_no_done", done_cnt - d0, 32'd0);
        check("mid_rst_c2", ram[8'hC2], 32'hB2);
        check("mid_rst_c3", ram[8'hC3], 32'h5555_00C3);
        check("mid_rst_c7", ram[8'hC7], 32'h5555_00C7);
        for (int unsigned i = 3; i < 8; i++) exp_mem[8'hC0 + i] = 32'h5555_00C0 + i;
        wq.delete(); wq.push_back(32'h77);
        d0 = done_cnt;
        write_burst(8'hC5, 8'd0, 1);
        wait_done("post_rst_done", d0);
        check("post_rst_ram", ram[8'hC5], 32'h77);

        // Full 256-beat write and read
        fill_wq(32'd0, 256);
        d0 = done_cnt;
        write_burst(8'h00, 8'd255, 256);
        wait_done("full_wr_done", d0);
        check("full_wr_addr", {24'd0, dut.addr_q}, 32'd0);
        check("full_ram_ff", ram[8'hFF], 32'hFF);
        p0 = n_popped; d0 = done_cnt;
        read_burst(8'h00, 8'd255);
        wait_done("full_rd_done", d0);
        check("full_rd_beats", n_popped - p0, 32'd256);
        check("full_rd_addr", {24'd0, dut.addr_q}, 32'd0);
        check("sb_empty", sb.size(), 32'd0);
        check("no_conflict", n_conflict, 32'd0);
        check("drive_only_strobe", n_drive_err, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_master.md
Name: ram_master

Overview:
- Initiator for the 256x32 single-port RAM bus: wr_en, rd_en, 8-bit addr and a shared 32-bit tri-state data bus.
- Accepts burst requests on a valid/ready command port.
- Sources write data from a valid/ready stream and returns read data on a valid/ready stream.
- Owns bus direction and read-latency timing, so client logic never touches the tri-state bus.

Parameters:
- AW, 8, address width (256 words).
- DW, 32, data width.

Ports:
- clk_i  input  1  single clock; all logic is on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req_valid_i  input  1  burst request valid.
- req_ready_o  output  1  high only in IDLE.
- req_wr_i  input  1  1 = write burst, 0 = read burst.
- req_addr_i  input  AW  start address.
- req_len_i  input  AW  beat count minus 1 (0 gives 1 beat, 255 gives 256 beats).
- wdata_valid_i  input  1  write beat available.
- wdata_i  input  DW  write beat data.
- wdata_ready_o  output  1  write beat consumed this cycle.
- rdata_valid_o  output  1  read beat valid.
- rdata_o  output  DW  read beat data.
- rdata_ready_i  input  1  consumer accepts read beat.
- busy_o  output  1  high whenever state is not IDLE.
- done_o  output  1  one-cycle pulse after the last beat of a burst.
- mem_wr_en_o  output  1  RAM write enable.
- mem_rd_en_o  output  1  RAM read enable.
- mem_addr_o  output  AW  RAM address.
- mem_data_io  inout  DW  RAM data bus.

Behaviour:
- Reset (async, rst_i=1), all registered outputs forced:
  - mem_wr_en_o=0, mem_rd_en_o=0, mem_addr_o=0.
  - rdata_valid_o=0, rdata_o=0, done_o=0.
  - State = IDLE. mem_data_io released to Z.
- Reset mid-burst: burst abandoned, remaining beats dropped, no done_o pulse; bus released in the same cycle rst_i rises.
- Bus ownership:
  - mem_data_io is driven only when the registered write-drive flag is 1; it carries the registered write data.
  - Otherwise mem_data_io is Z.
  - mem_wr_en_o and mem_rd_en_o are never both 1.
  - Drive and mem_rd_en_o are never both 1.
- States: IDLE, WR, RD_ADDR, RD_CAP, RD_OUT, DONE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch addr into addr_q, len into cnt_q and direction.
  - Go to WR (write) or RD_ADDR (read).
- WR:
  - wdata_ready_o=1 combinationally in WR.
  - On each cycle with wdata_valid_i=1: register mem_wr_en_o=1, mem_addr_o=addr_q, drive data=wdata_i for exactly the next cycle.
  - The RAM samples the beat on the following edge.
  - Then addr_q+1, cnt_q-1.
  - Beat taken with cnt_q==0 goes to DONE; the last write strobe completes during DONE.
  - wdata_valid_i=0: no strobe issued, stay in WR. Stalls are unbounded.
- RD_ADDR (1 cycle): mem_rd_en_o=1, mem_addr_o=addr_q. The RAM registers the word at the edge.
- RD_CAP (1 cycle):
  - mem_rd_en_o held at 1, so the RAM drives the bus.
  - Capture mem_data_io into rdata_o at the edge.
  - Drop mem_rd_en_o and go to RD_OUT.
- RD_OUT:
  - rdata_valid_o=1, rdata_o stable until rdata_ready_i=1.
  - On acceptance: addr_q+1, cnt_q-1.
  - cnt_q==0 goes to DONE, else RD_ADDR.
  - Minimum 3 cycles per read beat.
- DONE: done_o=1 for one cycle, write strobe deasserted, bus Z, then IDLE. busy_o=1 in DONE.
- Arithmetic:
  - addr_q wraps modulo 2^AW (0xFF+1 gives 0x00).
  - cnt_q is AW bits and counts down; a burst of req_len_i+1 beats never exceeds 256.
- Request inputs are sampled only on an IDLE handshake; later changes are ignored.
- wdata_ready_o=0 outside WR.
- rdata_ready_i is ignored outside RD_OUT.

Decomposition:
- Package ram_master_pkg holds:
  - State enum.
  - Constants AW_DEF=8, DW_DEF=32, DEPTH=256.
  - Bus idle value: all-Z DW-wide.
- No sub-module needed; the tri-state driver is a single continuous assignment in the top.
- Bench reuses the existing ram block as the slave model on mem_* ports.

Test Plan:
- Write len=3 at addr 0xFE with data 0xA0..0xA3, then read len=3 at 0xFE -> rdata sequence 0xA0,0xA1,0xA2,0xA3. RAM[0xFE]=0xA0, RAM[0xFF]=0xA1, RAM[0x00]=0xA2, RAM[0x01]=0xA3 (wrap). One done_o pulse per burst.
- Single read len=0 at 0x10 holding 0x12345678 -> mem_rd_en_o high exactly 2 cycles. rdata_valid_o rises 3 cycles after the req handshake with 0x12345678.
- rdata_ready_i held low 5 cycles during a 2-beat read -> rdata_o/rdata_valid_o stable. No new mem_rd_en_o until accept. Both beats correct.
- Write burst len=2 with wdata_valid_i gaps of 0/3/1 cycles -> exactly 3 mem_wr_en_o pulses of 1 cycle each. Bus Z in every non-strobe cycle. busy_o=1 throughout.
- rst_i asserted mid 8-beat write after 3 beats -> all mem_* low and bus Z immediately. No done_o pulse. Only the first 3 beats land; a new request is accepted after release.
- Full burst len=255 write then read from 0x00, data=address -> 256 beats, final addr wraps to 0x00. Every readback matches. No cycle with wr_en and rd_en both high.
